tt_um_mikegoelzer_7seg_scroller: RTL and testbench
==================================================

TT_UM_MIKEGOELZER_7SEG_SCROLLER -- requirements
Module: tt_um_mikegoelzer_7seg_scroller

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 5000000, clocks each digit is lit.
REQ-002 SHALL have parameter GAP_CYCLES, default 1000000, blank clocks between digits; the end-of-word blank is 2*GAP_CYCLES.
REQ-003 SHALL have parameter CNT_W, default 24, timer width; it must hold DWELL_CYCLES and 2*GAP_CYCLES.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port ena, input, 1 bit: ignored.
REQ-007 SHALL have port ui_in, input, 8 bits: byte to display.
REQ-008 SHALL have port uio_in, input, 8 bits: [0] load (rising edge); [1] mode (0 = hex, 1 = decimal); [7:2] unused.
REQ-009 SHALL have port uo_out, output, 8 bits: [6:0] segments a..g, active high; [7] dp.
REQ-010 SHALL have port uio_out, output, 8 bits: [4] busy; [6:5] index of the current digit; all other bits 0.
REQ-011 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-012 SHALL pass uio_in[0] through a 2-flop synchroniser plus an edge-detect flop; a 0->1 edge SHALL produce a one-cycle load pulse.
REQ-013 SHALL, on the load pulse, capture ui_in and uio_in[1] into value and mode registers; these registers SHALL stay stable until the next load.
REQ-014 SHALL implement states IDLE, CONV, SHOW, GAP and TAIL.
REQ-015 SHALL hold uo_out = 0 while in IDLE, CONV, GAP or TAIL.
REQ-016 SHALL perform CONV in 1 clock in hex mode (2 digits: high nibble, then low nibble).
REQ-017 SHALL perform CONV in decimal mode as a sequential shift-add-3 over 8 clocks, one bit per clock (3 BCD digits, hundreds first).
REQ-018 SHALL transition CONV->SHOW with digit index = first displayed digit.
REQ-019 SHALL stay in SHOW for DWELL_CYCLES clocks, then go to GAP if more digits remain, otherwise to TAIL.
REQ-020 SHALL stay in GAP for GAP_CYCLES clocks, then go to SHOW with the next digit.
REQ-021 SHALL stay in TAIL for 2*GAP_CYCLES clocks, then go to SHOW with the first digit; the word repeats forever.
REQ-022 SHALL drive segments in SHOW using the encoding 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 SHALL set uo_out[7] only while showing the last digit of a word.
REQ-024 SHALL make a load pulse in any state abort the current word and enter CONV on the next clock, timer cleared.
REQ-025 SHALL give a pin-to-CONV latency of 3 clocks.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL clear the timer on every state transition.
REQ-028 SHALL compare the timer against the parameter minus 1, so that DWELL_CYCLES = 1 gives a 1-clock digit.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force: state = IDLE, timer = 0, value = 0, mode = 0, synchroniser flops = 0, uo_out = 0, uio_out = 0.
REQ-030 SHALL keep uio_oe at 8'hF0 during reset.
REQ-031 SHALL return to IDLE with a blank display when reset is asserted mid-word; no word resumes until a new load.

Configuration
REQ-032 SHALL, when macro TT7_LEADING_ZERO_SUPPRESS_EN is defined, skip leading zero digits in decimal mode, with at least one digit always shown; value 0 shows "0".
REQ-033 SHALL, when TT7_LEADING_ZERO_SUPPRESS_EN is undefined, always show all 3 decimal digits.
REQ-034 SHALL leave hex mode unaffected by TT7_LEADING_ZERO_SUPPRESS_EN in both cases.

Verification (DWELL_CYCLES=4, GAP_CYCLES=2)
REQ-035 SHALL cover reset: rst_n low -> uo_out=00, uio_out=00, uio_oe=F0; after release, uo_out stays 00 with no load.
REQ-036 SHALL cover hex load: ui_in=A5, mode 0, load edge -> 77 x4, 00 x2, ED x4, 00 x4, repeat; busy=1.
REQ-037 SHALL cover decimal load: ui_in=FF, mode 1 -> CONV 8 clocks, then 5B x4, 00 x2, 6D x4, 00 x2, ED x4, 00 x4.
REQ-038 SHALL cover decimal zero handling: ui_in=07, mode 1 -> with macro: 87 x4 then 00 x4 repeating; without macro: 3F, 3F, 87.
REQ-039 SHALL cover reload mid-word: during SHOW of 77, load ui_in=01 hex -> blank within 4 clocks of the pin edge, then 3F x4, 00 x2, 86 x4.
REQ-040 SHALL cover reset mid-word: rst_n pulsed low during GAP -> uo_out=00 immediately, busy=0, stays idle until the next load.

Source files
------------

// File: rtl/tt_um_mikegoelzer_7seg_scroller.sv
// rtl/tt_um_mikegoelzer_7seg_scroller.sv - scrolls a loaded byte one hex/decimal digit at a time on a 7-seg display
// Optional macro TT7_LEADING_ZERO_SUPPRESS_EN: skip leading zero digits in decimal mode.
module tt_um_mikegoelzer_7seg_scroller #(
    parameter int DWELL_CYCLES = 5000000,
    parameter int GAP_CYCLES   = 1000000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [2:0] {ST_IDLE, ST_CONV, ST_SHOW, ST_GAP, ST_TAIL} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(2 * GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(7);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       value_q, value_d;
    logic             mode_q, mode_d;
    logic [7:0]       bin_q, bin_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       first_q, first_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic [7:0]       uo_out_q, uo_out_d;
    logic [7:0]       uio_out_q, uio_out_d;
    logic             load_pulse;
    logic             unused_ok;

    assign unused_ok = &{ena, uio_in[7:2]};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    // Hex words read straight from the captured byte; decimal words from the BCD result.
    function automatic logic [3:0] digit_at(input logic mode, input logic [1:0] idx,
                                            input logic [7:0] value, input logic [11:0] bcd);
        if (!mode) begin
            digit_at = idx[0] ? value[3:0] : value[7:4];
        end else begin
            case (idx)
                2'd0:    digit_at = bcd[11:8];
                2'd1:    digit_at = bcd[7:4];
                default: digit_at = bcd[3:0];
            endcase
        end
    endfunction

    function automatic logic [11:0] add3(input logic [11:0] bcd);
        for (int i = 0; i < 3; i++) begin
            add3[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
    endfunction

    always_comb begin
        sync1_d    = uio_in[0];
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        load_pulse = sync2_q & ~sync3_q;
        state_d    = state_q;
        timer_d    = timer_q + CNT_W'(1);
        value_d    = value_q;
        mode_d     = mode_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        idx_d      = idx_q;
        first_d    = first_q;

        if (load_pulse) begin
            state_d = ST_CONV;
            timer_d = '0;
            value_d = ui_in;
            mode_d  = uio_in[1];
            bin_d   = ui_in;
            bcd_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: timer_d = '0;
                ST_CONV: begin
                    if (!mode_q) begin
                        state_d = ST_SHOW;
                        timer_d = '0;
                        first_d = 2'd0;
                        idx_d   = 2'd0;
                    end else begin
                        {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
                        if (timer_q == CONV_LAST) begin
                            state_d = ST_SHOW;
                            timer_d = '0;
`ifdef TT7_LEADING_ZERO_SUPPRESS_EN
                            if (bcd_d[11:8] != 4'd0)     first_d = 2'd0;
                            else if (bcd_d[7:4] != 4'd0) first_d = 2'd1;
                            else                         first_d = 2'd2;
`else
                            first_d = 2'd0;
`endif
                            idx_d = first_d;
                        end
                    end
                end
                ST_SHOW: begin
                    if (timer_q == DWELL_LAST) begin
                        timer_d = '0;
                        state_d = (idx_q == (mode_q ? 2'd2 : 2'd1)) ? ST_TAIL : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_d = '0;
                        state_d = ST_SHOW;
                        idx_d   = idx_q + 2'd1;
                    end
                end
                ST_TAIL: begin
                    if (timer_q == TAIL_LAST) begin
                        timer_d = '0;
                        state_d = ST_SHOW;
                        idx_d   = first_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs are computed from next-state so they line up with the registered state.
        if (state_d == ST_SHOW) begin
            uo_out_d = {idx_d == (mode_d ? 2'd2 : 2'd1),
                        seg7(digit_at(mode_d, idx_d, value_d, bcd_d))};
        end else begin
            uo_out_d = '0;
        end
        uio_out_d = {1'b0, idx_d, state_d != ST_IDLE, 4'b0000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            value_q   <= '0;
            mode_q    <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            idx_q     <= 2'd0;
            first_q   <= 2'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            uo_out_q  <= '0;
            uio_out_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            value_q   <= value_d;
            mode_q    <= mode_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            uo_out_q  <= uo_out_d;
            uio_out_q <= uio_out_d;
        end
    end

    assign uo_out  = uo_out_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_mikegoelzer_7seg_scroller.sv
// tb/tb_tt_um_mikegoelzer_7seg_scroller.sv - directed table-driven bench for the 7-seg scroller
module tb_tt_um_mikegoelzer_7seg_scroller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    tt_um_mikegoelzer_7seg_scroller #(
        .DWELL_CYCLES(4),
        .GAP_CYCLES  (2),
        .CNT_W       (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] ui;
        logic       mode;
        logic [7:0] val [8];
        int         cnt [8];
    } vec_t;

    vec_t vecs [7];

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Raises the load pin at a falling edge, drops it one cycle later, returns two falling edges after the rise.
    task automatic start_load(input logic [7:0] v, input logic m);
        @(negedge clk);
        ui_in     = v;
        uio_in[1] = m;
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check8({nm, "_seg"}, uo_out, v);
            check8({nm, "_busy"}, {7'd0, uio_out[4]}, 8'h01);
        end
    endtask

    initial begin
        vecs[0] = '{"hex_a5", 8'hA5, 1'b0,
                    '{8'h00, 8'h77, 8'h00, 8'hED, 8'h00, 8'h77, 8'h00, 8'h00}, '{1, 4, 2, 4, 4, 4, 0, 0}};
        vecs[1] = '{"hex_0f", 8'h0F, 1'b0,
                    '{8'h00, 8'h3F, 8'h00, 8'hF1, 8'h00, 8'h3F, 8'h00, 8'h00}, '{1, 4, 2, 4, 4, 1, 0, 0}};
        vecs[2] = '{"dec_255", 8'hFF, 1'b1,
                    '{8'h00, 8'h5B, 8'h00, 8'h6D, 8'h00, 8'hED, 8'h00, 8'h5B}, '{8, 4, 2, 4, 2, 4, 4, 1}};
        vecs[3] = '{"dec_100", 8'h64, 1'b1,
                    '{8'h00, 8'h06, 8'h00, 8'h3F, 8'h00, 8'hBF, 8'h00, 8'h06}, '{8, 4, 2, 4, 2, 4, 4, 1}};
`ifdef TT7_LEADING_ZERO_SUPPRESS_EN
        vecs[4] = '{"dec_7", 8'h07, 1'b1,
                    '{8'h00, 8'h87, 8'h00, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00}, '{8, 4, 4, 4, 4, 0, 0, 0}};
        vecs[5] = '{"dec_0", 8'h00, 1'b1,
                    '{8'h00, 8'hBF, 8'h00, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00}, '{8, 4, 4, 4, 0, 0, 0, 0}};
`else
        vecs[4] = '{"dec_7", 8'h07, 1'b1,
                    '{8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h87, 8'h00, 8'h3F}, '{8, 4, 2, 4, 2, 4, 4, 1}};
        vecs[5] = '{"dec_0", 8'h00, 1'b1,
                    '{8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'hBF, 8'h00, 8'h3F}, '{8, 4, 2, 4, 2, 4, 4, 1}};
`endif
        vecs[6] = '{"dec_42", 8'h2A, 1'b1,
                    '{8'h00, 8'h3F, 8'h00, 8'h66, 8'h00, 8'hDB, 8'h00, 8'h00}, '{8, 4, 2, 4, 2, 4, 4, 0}};
`ifdef TT7_LEADING_ZERO_SUPPRESS_EN
        vecs[6] = '{"dec_42", 8'h2A, 1'b1,
                    '{8'h00, 8'h66, 8'h00, 8'hDB, 8'h00, 8'h66, 8'h00, 8'h00}, '{8, 4, 2, 4, 4, 4, 0, 0}};
`endif

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        repeat (3) @(negedge clk);
        check8("rst_uo_out", uo_out, 8'h00);
        check8("rst_uio_out", uio_out, 8'h00);
        check8("rst_uio_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check8("idle_uo_out", uo_out, 8'h00);
            check8("idle_uio_out", uio_out, 8'h00);
        end

        // Pin rise to CONV takes three clocks; hex CONV takes one more.
        start_load(8'h0F, 1'b0);
        check8("lat_not_yet_busy", uio_out, 8'h00);
        @(negedge clk);
        check8("lat_conv_busy", uio_out, 8'h10);
        check8("lat_conv_blank", uo_out, 8'h00);
        @(negedge clk);
        check8("lat_first_digit", uo_out, 8'h3F);

        for (int v = 0; v < 7; v++) begin
            start_load(vecs[v].ui, vecs[v].mode);
            for (int p = 0; p < 8; p++) begin
                run(vecs[v].name, vecs[v].val[p], vecs[v].cnt[p]);
            end
        end

        // Reload in the middle of a word.
        start_load(8'hA5, 1'b0);
        run("reload_pre", 8'h00, 1);
        run("reload_pre", 8'h77, 2);
        start_load(8'h01, 1'b0);
        run("reload_conv", 8'h00, 1);
        run("reload_d0", 8'h3F, 4);
        check8("reload_idx0", uio_out, 8'h10);
        run("reload_gap", 8'h00, 2);
        run("reload_d1", 8'h86, 4);
        check8("reload_idx1", uio_out, 8'h30);

        // Reset asserted while in the inter-digit gap.
        start_load(8'hA5, 1'b0);
        run("rstmid_pre", 8'h00, 1);
        run("rstmid_pre", 8'h77, 4);
        run("rstmid_gap", 8'h00, 1);
        rst_n = 1'b0;
        #1;
        check8("rstmid_uo_out", uo_out, 8'h00);
        check8("rstmid_uio_out", uio_out, 8'h00);
        check8("rstmid_uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check8("rstmid_idle_uo", uo_out, 8'h00);
            check8("rstmid_idle_uio", uio_out, 8'h00);
        end
        start_load(8'h0F, 1'b0);
        run("rstmid_after", 8'h00, 1);
        run("rstmid_after", 8'h3F, 4);
        run("rstmid_after_gap", 8'h00, 2);
        run("rstmid_after", 8'hF1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
